// File: rtl/adder_fifo_pkg.sv
// Shared types and constants for the adder operand fork.
//   operand_t : one operand at the default interface width
//   BUF_DEPTH : entries per branch buffer
//   occ_t     : branch buffer occupancy (0..BUF_DEPTH)
package adder_fifo_pkg;

    localparam int DEFAULT_DATA_IN_WIDTH = 8;
    typedef logic [DEFAULT_DATA_IN_WIDTH-1:0] operand_t;

    localparam int BUF_DEPTH = 2;
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_FULL = occ_t'(BUF_DEPTH);

endpackage

// File: rtl/operand_skid_buf.sv
// Two-entry FIFO holding one branch of the operand fork.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, empties buffer and clears storage
//   push      : write push_data (caller guarantees buffer not full)
//   push_data : operand to store
//   ready     : downstream accepts the head entry
//   data      : head entry, driven straight from storage
//   valid     : buffer non-empty
//   occ       : registered occupancy
module operand_skid_buf
    import adder_fifo_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output occ_t         occ
);

    logic [W-1:0] mem_reg [BUF_DEPTH];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    occ_t         occ_reg;

    logic do_push;
    logic do_pop;

    assign valid   = (occ_reg != 2'd0);
    assign occ     = occ_reg;
    // Storage is cleared on reset, so the head reads as zero while empty after reset.
    assign data    = mem_reg[rd_ptr_reg];
    assign do_pop  = valid & ready;
    // Guard is redundant with the top-level ready, but keeps the buffer self-protecting.
    assign do_push = push & (occ_reg != OCC_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/adder_operand_fork.sv
// Forks a stream of operand pairs {a, b} into two independent valid/ready
// streams, one per adder input port, each backed by a 2-entry buffer.
// Ports:
//   clk_i, arst_n          : clock and synchronous active-low reset
//   pair_a, pair_b         : incoming operand pair
//   pair_valid, pair_ready : input handshake
//   fifo_1_in*             : operand A stream toward adder port 1
//   fifo_2_in*             : operand B stream toward adder port 2
//   pair_count             : pairs accepted since reset, wrapping
module adder_operand_fork
    import adder_fifo_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_n,
    input  logic [DATA_IN_WIDTH-1:0] pair_a,
    input  logic [DATA_IN_WIDTH-1:0] pair_b,
    input  logic                     pair_valid,
    output logic                     pair_ready,
    output logic [DATA_IN_WIDTH-1:0] fifo_1_in,
    output logic                     fifo_1_in_valid,
    input  logic                     fifo_1_in_ready,
    output logic [DATA_IN_WIDTH-1:0] fifo_2_in,
    output logic                     fifo_2_in_valid,
    input  logic                     fifo_2_in_ready
    ,
    output logic [CNT_WIDTH-1:0]     pair_count
);

    localparam int NUM_BRANCHES = 2;

    logic                     run_reg;
    logic [CNT_WIDTH-1:0]     pair_count_reg;
    logic                     accept;

    logic [DATA_IN_WIDTH-1:0] push_data   [NUM_BRANCHES];
    logic                     br_ready    [NUM_BRANCHES];
    logic [DATA_IN_WIDTH-1:0] br_data     [NUM_BRANCHES];
    logic                     br_valid    [NUM_BRANCHES];
    occ_t                     br_occ      [NUM_BRANCHES];

    // run_reg holds pair_ready low during reset and releases it on the first
    // edge that samples arst_n high. Ready depends only on registered state,
    // so there is no combinational path from the downstream readies.
    assign pair_ready = run_reg & (br_occ[0] < OCC_FULL) & (br_occ[1] < OCC_FULL);
    assign accept     = pair_valid & pair_ready;

    assign push_data[0] = pair_a;
    assign push_data[1] = pair_b;
    assign br_ready[0]  = fifo_1_in_ready;
    assign br_ready[1]  = fifo_2_in_ready;

    // Both branches are pushed on the same handshake, which is what keeps the
    // k-th entry of each branch belonging to the same pair.
    generate
        for (genvar gi = 0; gi < NUM_BRANCHES; gi++) begin : g_branch
            operand_skid_buf #(
                .W(DATA_IN_WIDTH)
            ) u_buf (
                .clk       (clk_i),
                .rst_n     (arst_n),
                .push      (accept),
                .push_data (push_data[gi]),
                .ready     (br_ready[gi]),
                .data      (br_data[gi]),
                .valid     (br_valid[gi]),
                .occ       (br_occ[gi])
            );
        end
    endgenerate

    assign fifo_1_in       = br_data[0];
    assign fifo_1_in_valid = br_valid[0];
    assign fifo_2_in       = br_data[1];
    assign fifo_2_in_valid = br_valid[1];
    assign pair_count      = pair_count_reg;

    always_ff @(posedge clk_i) begin
        if (!arst_n) begin
            run_reg        <= 1'b0;
            pair_count_reg <= '0;
        end else begin
            run_reg <= 1'b1;
            if (accept) begin
                pair_count_reg <= pair_count_reg + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_operand_fork.sv
module tb_adder_operand_fork;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic          clk_i = 1'b0;
    logic          arst_n = 1'b0;
    logic [W-1:0]  pair_a = '0;
    logic [W-1:0]  pair_b = '0;
    logic          pair_valid = 1'b0;
    logic          pair_ready;
    logic [W-1:0]  fifo_1_in;
    logic          fifo_1_in_valid;
    logic          fifo_1_in_ready = 1'b1;
    logic [W-1:0]  fifo_2_in;
    logic          fifo_2_in_valid;
    logic          fifo_2_in_ready = 1'b1;
    logic [CW-1:0] pair_count;

    int checks = 0;
    int errors = 0;

    adder_operand_fork #(
        .DATA_IN_WIDTH(W),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i           (clk_i),
        .arst_n          (arst_n),
        .pair_a          (pair_a),
        .pair_b          (pair_b),
        .pair_valid      (pair_valid),
        .pair_ready      (pair_ready),
        .fifo_1_in       (fifo_1_in),
        .fifo_1_in_valid (fifo_1_in_valid),
        .fifo_1_in_ready (fifo_1_in_ready),
        .fifo_2_in       (fifo_2_in),
        .fifo_2_in_valid (fifo_2_in_valid),
        .fifo_2_in_ready (fifo_2_in_ready),
        .pair_count      (pair_count)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: each branch is just an ordered queue of operands not
    // yet taken downstream; accepting a pair appends to both queues.
    int q1[$];
    int q2[$];
    int model_cnt = 0;
    bit model_run = 0;
    int pops1 = 0;

    initial begin
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            begin
                bit exp_ready;
                bit acc;
                bit p1;
                bit p2;
                exp_ready = model_run && (q1.size() < 2) && (q2.size() < 2);
                chk("pair_ready", pair_ready, exp_ready);
                chk("valid1", fifo_1_in_valid, q1.size() != 0);
                chk("valid2", fifo_2_in_valid, q2.size() != 0);
                if (q1.size() != 0) chk("data1", fifo_1_in, q1[0]);
                if (q2.size() != 0) chk("data2", fifo_2_in, q2[0]);
                if (!model_run) begin
                    chk("data1_rst", fifo_1_in, 0);
                    chk("data2_rst", fifo_2_in, 0);
                end
                chk("pair_count", pair_count, model_cnt);

                if (!arst_n) begin
                    q1.delete();
                    q2.delete();
                    model_cnt = 0;
                    model_run = 0;
                end else begin
                    acc = pair_valid && exp_ready;
                    p1  = (q1.size() != 0) && fifo_1_in_ready;
                    p2  = (q2.size() != 0) && fifo_2_in_ready;
                    if (p1) begin void'(q1.pop_front()); pops1++; end
                    if (p2) void'(q2.pop_front());
                    if (acc) begin
                        q1.push_back(int'(pair_a));
                        q2.push_back(int'(pair_b));
                        model_cnt = (model_cnt + 1) % MOD;
                    end
                    model_run = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input int a, input int b);
        int n;
        n = 0;
        pair_a = W'(a);
        pair_b = W'(b);
        pair_valid = 1'b1;
        while (!pair_ready && n < 50) begin
            step();
            n++;
        end
        chk("offer_timeout", n < 50, 1);
        step();
        pair_valid = 1'b0;
    endtask

    initial begin
        int accepted;
        int cyc;
        logic [CW-1:0] snap;

        // Reset
        arst_n = 1'b0;
        repeat (3) step();
        chk("rst_ready", pair_ready, 0);
        chk("rst_count", pair_count, 0);
        arst_n = 1'b1;
        step();
        chk("first_ready", pair_ready, 1);

        // Back-to-back pairs with both readies high
        offer(3, 5);
        offer(7, 9);
        offer(255, 1);
        chk("s1_count", pair_count, 3);
        repeat (3) step();

        // Branch 2 stalled
        fifo_1_in_ready = 1'b1;
        fifo_2_in_ready = 1'b0;
        offer(1, 2);
        offer(3, 4);
        pair_a = 8'd5;
        pair_b = 8'd6;
        pair_valid = 1'b1;
        repeat (4) begin
            chk("s2_hold_ready", pair_ready, 0);
            chk("s2_hold_b", fifo_2_in, 2);
            step();
        end
        fifo_2_in_ready = 1'b1;
        offer(5, 6);
        repeat (4) step();

        // Both stalled with full buffers
        fifo_1_in_ready = 1'b0;
        fifo_2_in_ready = 1'b0;
        offer(10, 20);
        offer(30, 40);
        snap = pair_count;
        pair_a = 8'd50;
        pair_b = 8'd60;
        pair_valid = 1'b1;
        repeat (10) step();
        chk("s3_count_held", pair_count, snap);
        chk("s3_a_held", fifo_1_in, 10);
        chk("s3_b_held", fifo_2_in, 20);
        pair_valid = 1'b0;

        // Reset with both branches full
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        chk("s4_valid1", fifo_1_in_valid, 0);
        chk("s4_valid2", fifo_2_in_valid, 0);
        chk("s4_count", pair_count, 0);
        chk("s4_ready_low", pair_ready, 0);
        fifo_1_in_ready = 1'b1;
        fifo_2_in_ready = 1'b1;
        step();
        chk("s4_ready_high", pair_ready, 1);
        repeat (3) step();

        // Counter wrap: 17 pairs on a 4-bit counter
        for (int i = 0; i < 17; i++) offer(i, 100 + i);
        chk("s5_wrap", pair_count, 1);
        repeat (3) step();

        // Random traffic with independent stalls
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            pair_a = W'($urandom_range(0, 255));
            pair_b = W'($urandom_range(0, 255));
            pair_valid = ($urandom_range(0, 3) != 0);
            fifo_1_in_ready = ($urandom_range(0, 3) != 0);
            fifo_2_in_ready = ($urandom_range(0, 2) != 0);
            if (pair_valid && pair_ready) accepted++;
            step();
            cyc++;
        end
        chk("s6_done", accepted, 1000);
        pair_valid = 1'b0;
        fifo_1_in_ready = 1'b1;
        fifo_2_in_ready = 1'b1;
        repeat (5) step();
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        chk("drain_v1", fifo_1_in_valid, 0);
        chk("drain_v2", fifo_2_in_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_operand_fork.md
Name: adder_operand_fork

Overview:
Transmit side of the adder's operand interface. It accepts one stream of operand pairs {a, b} over valid/ready. It forks each pair into two independent valid/ready streams, one per adder input FIFO port (fifo_1_in*, fifo_2_in*). Each branch has a 2-entry buffer, so the two downstream consumers can stall independently while pair order and pairing are preserved.

Parameters:
DATA_IN_WIDTH, 8, width of each operand; must equal the adder interface DATA_IN_WIDTH (must be >= 1)
CNT_WIDTH, 16, width of the accepted-pair counter

Ports:
clk_i  input  1  clock, all logic on rising edge
arst_n  input  1  reset, synchronous, active-low
pair_a  input  DATA_IN_WIDTH  operand A of incoming pair
pair_b  input  DATA_IN_WIDTH  operand B of incoming pair
pair_valid  input  1  incoming pair valid
pair_ready  output  1  block can accept a pair
fifo_1_in  output  DATA_IN_WIDTH  operand A toward adder port 1
fifo_1_in_valid  output  1  branch 1 data valid
fifo_1_in_ready  input  1  adder port 1 accepts
fifo_2_in  output  DATA_IN_WIDTH  operand B toward adder port 2
fifo_2_in_valid  output  1  branch 2 data valid
fifo_2_in_ready  input  1  adder port 2 accepts
pair_count  output  CNT_WIDTH  number of pairs accepted since reset, wrapping

Behaviour:
- Reset is sampled on the clock edge while arst_n=0. While in reset, all of the following hold:
  - both branch buffers are emptied (occupancy 0, read/write pointers 0);
  - fifo_1_in_valid=0, fifo_2_in_valid=0;
  - fifo_1_in=0, fifo_2_in=0;
  - pair_count=0;
  - pair_ready=0.
- The first cycle after arst_n returns to 1 has pair_ready=1.
- Reset asserted mid-operation discards every buffered operand. No partial pair survives.
- Input handshake is pair_valid & pair_ready.
  - pair_ready = (occ1 < 2) & (occ2 < 2), taken from registered occupancy only.
  - pair_ready has no combinational path from fifo_x_in_ready.
- On an input handshake, pair_a is written to branch 1 and pair_b to branch 2 in the same cycle. pair_count increments by 1 and wraps from 2^CNT_WIDTH-1 to 0.
- Each branch is a 2-entry FIFO with a 1-bit write pointer, 1-bit read pointer and a 2-bit occupancy.
  - fifo_x_in_valid = (occ_x != 0).
  - fifo_x_in = entry at the read pointer, driven directly from storage. It is held stable while valid=1 and ready=0.
- Branch pop is fifo_x_in_valid & fifo_x_in_ready. Branches pop independently. One branch may run up to 2 entries ahead of the other.
- Occupancy update per branch: push and no pop gives +1; pop and no push gives -1; push and pop gives no change.
  - Push is impossible at occ=2 (pair_ready=0).
  - Pop is impossible at occ=0.
- Latency: a pair accepted on edge N is visible on both fifo_x_in outputs in the cycle after edge N. This applies when the branch was empty. Otherwise it waits behind older entries.
- Throughput: 1 pair/cycle while both downstream readies stay 1 (occ oscillates 1 -> 1).
- Ordering: branch 1 and branch 2 present operands in accepted order. The k-th pop of branch 1 and the k-th pop of branch 2 always belong to the same pair.
- pair_valid=0 has no effect on state. pair_a and pair_b are ignored without a handshake.

Decomposition:
- Package adder_fifo_pkg:
  - typedef operand_t (logic [DATA_IN_WIDTH-1:0] at the default width);
  - localparam BUF_DEPTH=2;
  - typedef occ_t (logic [1:0]).
- One sub-module, operand_skid_buf. It holds the 2-entry FIFO with push/pop, data, valid and occupancy. It is instantiated twice, once per branch.
- The top level holds pair_ready, the pair counter and the wiring.

Test Plan:
- Reset with both readies=1, then pairs (3,5), (7,9), (255,1) on consecutive cycles -> fifo_1_in sequence 3,7,255 and fifo_2_in sequence 5,9,1, one per cycle starting the cycle after each accept; pair_count=3.
- fifo_2_in_ready=0, fifo_1_in_ready=1, offer 3 pairs (1,2), (3,4), (5,6) -> pairs 1 and 2 accepted, pair_ready=0 from the cycle after the 2nd accept; branch 1 emits 1,3; fifo_2_in holds 2 with valid=1; release ready -> 2,4 emitted, then (5,6) accepted.
- Both readies=0 with a full buffer, hold 10 cycles -> outputs stable, pair_ready=0, pair_count unchanged.
- Assert arst_n=0 for 1 cycle with both branches holding 2 entries -> next cycle both valids=0 and pair_count=0; the following cycle pair_ready=1; no stale data is emitted afterwards.
- CNT_WIDTH=4, accept 17 pairs -> pair_count wraps 15 -> 0 -> 1.
- Random independent ready toggling, 1000 pairs -> scoreboard confirms per-branch order and a-b pairing are preserved and no drops or duplicates occur.
